// File: rtl/param_serializer_pkg.sv
// Shared types and helpers for the parametrised serializer.
// State encoding and the width helper used to size the bit counter.
package param_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Smallest n with 2**n >= v; evaluated at elaboration only.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/param_serializer.sv
// Parallel-to-serial converter: WIDTH-bit words out one bit per enabled clock, one-word holding buffer.
// First bit 1 edge after an idle write; out_ready drops while the buffer holds a word, extra writes are dropped and flagged.
module param_serializer
    import param_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             in_clock,
    input  logic             in_reset,
    input  logic             in_write,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_enable,
    output logic             out_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic             out_overrun
);

    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] hbuf_q, hbuf_d;
    logic             buf_full_q, buf_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             overrun_q;

    logic             accept;
    logic             at_last;
    logic [CW-1:0]    bit_idx;

    assign accept  = in_write & ~buf_full_q;
    assign at_last = (cnt_q == CNT_LAST);

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state_q    <= ST_IDLE;
            sreg_q     <= '0;
            hbuf_q     <= '0;
            buf_full_q <= 1'b0;
            cnt_q      <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            hbuf_q     <= hbuf_d;
            buf_full_q <= buf_full_d;
            cnt_q      <= cnt_d;
            // Judged against the pre-edge ready, so a same-edge buffer drain still flags it.
            if (in_write && buf_full_q) begin
                overrun_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        hbuf_d     = hbuf_q;
        buf_full_d = buf_full_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sreg_d  = in_data;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (accept) begin
                    hbuf_d     = in_data;
                    buf_full_d = 1'b1;
                end
                if (in_enable) begin
                    if (!at_last) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (buf_full_q) begin
                        sreg_d     = hbuf_q;
                        buf_full_d = 1'b0;
                        cnt_d      = '0;
                    end else if (accept) begin
                        // Word goes straight into the shifter instead of the buffer.
                        sreg_d     = in_data;
                        buf_full_d = 1'b0;
                        cnt_d      = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bit_idx     = LSB_FIRST ? cnt_q : (CNT_LAST - cnt_q);
    assign out_valid   = (state_q == ST_SHIFT);
    assign out_bit     = out_valid ? sreg_q[bit_idx] : IDLE_BIT;
    assign out_first   = out_valid && (cnt_q == '0);
    assign out_last    = out_valid && at_last;
    assign out_ready   = ~buf_full_q;
    assign out_overrun = overrun_q;

endmodule

// File: tb/tb_param_serializer.sv
// Scoreboard bench: stimulus pushes expected serial bits, negedge monitors pop and compare.
module tb_param_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       m_write, m_ready, m_bit, m_valid, m_first, m_last, m_ovr;
    logic [7:0] m_data;
    logic       l_write, l_ready, l_bit, l_valid, l_first, l_last, l_ovr;
    logic [7:0] l_data;

    int total = 0;
    int bad   = 0;
    logic [2:0] qm[$];
    logic [2:0] ql[$];

    always #5 clk = ~clk;

    param_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut (
        .in_clock(clk), .in_reset(rst), .in_write(m_write), .in_data(m_data),
        .in_enable(en), .out_ready(m_ready), .out_bit(m_bit), .out_valid(m_valid),
        .out_first(m_first), .out_last(m_last), .out_overrun(m_ovr)
    );

    param_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_l (
        .in_clock(clk), .in_reset(rst), .in_write(l_write), .in_data(l_data),
        .in_enable(en), .out_ready(l_ready), .out_bit(l_bit), .out_valid(l_valid),
        .out_first(l_first), .out_last(l_last), .out_overrun(l_ovr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entries are {bit, first, last}.
    task automatic push_msb(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) qm.push_back({w[i], i == 7, i == 0});
    endtask

    task automatic push_lsb(input logic [7:0] w);
        for (int i = 0; i < 8; i++) ql.push_back({w[i], i == 0, i == 7});
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid) begin
            if (qm.size() == 0) begin
                chk("msb_unexpected_valid", 32'(m_valid), 32'd0);
            end else begin
                chk("msb_bit_first_last", 32'({m_bit, m_first, m_last}), 32'(qm[0]));
                if (en) void'(qm.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && l_valid) begin
            if (ql.size() == 0) begin
                chk("lsb_unexpected_valid", 32'(l_valid), 32'd0);
            end else begin
                chk("lsb_bit_first_last", 32'({l_bit, l_first, l_last}), 32'(ql[0]));
                if (en) void'(ql.pop_front());
            end
        end
    end

    initial begin
        int nv;
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst = 1'b1; en = 1'b1;
        m_write = 1'b0; m_data = '0; l_write = 1'b0; l_data = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(m_ready), 32'd1);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_first_last", 32'({m_first, m_last}), 32'd0);
        chk("rst_bit", 32'(m_bit), 32'd0);
        chk("rst_overrun", 32'(m_ovr), 32'd0);
        chk("rst_lsb_idle_bit", 32'(l_bit), 32'd1);

        // Single word, MSB first
        m_data = 8'hAA; m_write = 1'b1; push_msb(8'hAA);
        tick();
        m_write = 1'b0;
        chk("single_first_after_write", 32'({m_valid, m_first}), 32'd3);
        repeat (8) tick();
        chk("single_idle_valid", 32'(m_valid), 32'd0);
        chk("single_idle_bit", 32'(m_bit), 32'd0);

        // Back-to-back through the holding buffer
        m_data = 8'hAA; m_write = 1'b1; push_msb(8'hAA);
        tick();
        m_write = 1'b0; nv = 0;
        if (m_valid) nv++;
        tick();
        if (m_valid) nv++;
        m_data = 8'h35; m_write = 1'b1; push_msb(8'h35);
        tick();
        m_write = 1'b0;
        if (m_valid) nv++;
        chk("b2b_ready_low", 32'(m_ready), 32'd0);
        for (int i = 3; i <= 15; i++) begin
            tick();
            if (m_valid) nv++;
            if (i == 7) chk("b2b_ready_before_xfer", 32'(m_ready), 32'd0);
            if (i == 8) chk("b2b_ready_after_xfer", 32'(m_ready), 32'd1);
        end
        chk("b2b_contiguous_bits", 32'(nv), 32'd16);
        tick();
        chk("b2b_idle_after", 32'(m_valid), 32'd0);

        // LSB-first instance with IDLE_BIT=1
        l_data = 8'h35; l_write = 1'b1; push_lsb(8'h35);
        tick();
        l_write = 1'b0;
        repeat (8) tick();
        chk("lsb_idle_valid", 32'(l_valid), 32'd0);
        chk("lsb_idle_bit", 32'(l_bit), 32'd1);

        // Enable gating: bits hold across disabled cycles
        m_data = 8'hAA; m_write = 1'b1; push_msb(8'hAA);
        tick();
        m_write = 1'b0;
        for (int i = 0; i < 16; i++) begin
            en = pat[i % 4];
            tick();
            if (i == 14) chk("en_still_active", 32'(m_valid), 32'd1);
        end
        en = 1'b1;
        chk("en_done", 32'(m_valid), 32'd0);

        // Overrun: third consecutive write is dropped
        m_data = 8'hC3; m_write = 1'b1; push_msb(8'hC3);
        tick();
        m_data = 8'h81; push_msb(8'h81);
        tick();
        chk("ovr_ready_low", 32'(m_ready), 32'd0);
        chk("ovr_not_yet", 32'(m_ovr), 32'd0);
        m_data = 8'h7E;
        tick();
        m_write = 1'b0;
        chk("ovr_set", 32'(m_ovr), 32'd1);
        repeat (20) tick();
        chk("ovr_sticky", 32'(m_ovr), 32'd1);
        chk("ovr_idle", 32'(m_valid), 32'd0);

        // Reset mid-word with the buffer full
        m_data = 8'hAA; m_write = 1'b1; push_msb(8'hAA);
        tick();
        m_data = 8'h35;
        tick();
        m_write = 1'b0;
        chk("mid_buf_full", 32'(m_ready), 32'd0);
        tick(); tick();
        rst = 1'b1;
        #1;
        qm.delete();
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_first_last", 32'({m_first, m_last}), 32'd0);
        chk("mid_rst_bit", 32'(m_bit), 32'd0);
        chk("mid_rst_ready", 32'(m_ready), 32'd1);
        chk("mid_rst_overrun", 32'(m_ovr), 32'd0);
        tick(); tick();
        rst = 1'b0;
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_valid) nv++;
        end
        chk("mid_no_residual_bits", 32'(nv), 32'd0);

        chk("msb_queue_drained", 32'(qm.size()), 32'd0);
        chk("lsb_queue_drained", 32'(ql.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_serializer.md
# param_serializer

Parametrised parallel-to-serial converter and successor to the fixed 8-bit serializer. It takes WIDTH-bit words through a write strobe and shifts them out one bit per enabled clock, MSB-first or LSB-first. A one-word holding buffer allows back-to-back words with no idle gap. Framing outputs (valid, first, last) and a sticky overrun flag are provided. It sits between a parallel producer and any bit-serial link stage driven by a shared bit-rate enable.

## Interface
Parameters:
- WIDTH, default 8: word width in bits; legal range is WIDTH >= 2.
- LSB_FIRST, default 0: 0 sends bit WIDTH-1 first; 1 sends bit 0 first.
- IDLE_BIT, default 0: value driven on out_bit whenever out_valid is 0.

Ports:
- in_clock, input, 1: the single clock; all state changes on its rising edge.
- in_reset, input, 1: asynchronous, active-high reset.
- in_write, input, 1: write strobe; the word is accepted at the edge where in_write=1 and out_ready=1.
- in_data, input, WIDTH: word to serialize; sampled only when a write is accepted.
- in_enable, input, 1: bit-rate enable; the bit position advances only on edges where in_enable=1.
- out_ready, output, 1: 1 when a write can be accepted (holding buffer empty).
- out_bit, output, 1: current serial bit.
- out_valid, output, 1: out_bit carries word data.
- out_first, output, 1: out_valid and the bit shown is the first bit of its word.
- out_last, output, 1: out_valid and the bit shown is the last bit of its word.
- out_overrun, output, 1: sticky flag, set by a write attempted while out_ready=0; cleared only by reset.

## Operation
- Storage:
  - shift register sreg (WIDTH bits),
  - bit counter cnt (clog2(WIDTH) bits),
  - holding buffer buf with full flag buf_full,
  - state register.
- States:
  - IDLE: no word active; out_valid=0.
  - SHIFT: a word is active; out_valid=1.
- out_ready = ~buf_full, decoded from registers only, never from in_write.
- Bit select: out_bit = sreg[WIDTH-1-cnt] when LSB_FIRST=0, sreg[cnt] when LSB_FIRST=1. Either a fixed index plus shifting or indexing by cnt is acceptable; the visible sequence must match.
- out_first = SHIFT && cnt==0. out_last = SHIFT && cnt==WIDTH-1.
- IDLE with write accepted: in_data loads directly into sreg; cnt=0; go to SHIFT. buf stays empty.
- SHIFT with write accepted: in_data loads into buf; buf_full=1.
- SHIFT, in_enable=1, cnt<WIDTH-1: cnt increments.
- SHIFT, in_enable=1, cnt==WIDTH-1 (end of word):
  - if buf_full: sreg=buf, buf_full=0, cnt=0, stay in SHIFT.
  - else if a write is accepted on the same edge: sreg=in_data, cnt=0, stay in SHIFT.
  - otherwise go to IDLE.
- in_enable=0: cnt, sreg and state hold, so out_bit is held. Writes are still accepted.
- in_enable has no effect in IDLE.
- A write when out_ready=0 is dropped (the word is lost) and sets out_overrun. This holds even if buf empties on that same edge.
- Reset values: state=IDLE, cnt=0, buf_full=0, out_ready=1, out_valid=0, out_first=0, out_last=0, out_bit=IDLE_BIT, out_overrun=0.
- Reset mid-word aborts the active word and the buffered word. No partial output follows after reset is released.

## Timing
- Write-to-first-bit latency: 1 edge. The word appears with out_first=1 immediately after the accepting edge when the block was idle.
- A word occupies exactly WIDTH enabled edges. With in_enable held at 1 it occupies WIDTH cycles.
- Back-to-back words: the next word's first bit directly follows the last bit with no idle cycle, provided buf was filled or a write is accepted on the last-bit edge.
- out_ready returns to 1 on the edge after buf transfers into sreg.
- Every output is a function of registers only; there is no combinational path from any input to any output.

## Structure
- The shared package holds:
  - the state encoding constants (ST_IDLE, ST_SHIFT),
  - a clog2 constant function used to size cnt.
- Single module with no sub-module. The holding buffer and shift path are too small to justify splitting.

## Test plan
- WIDTH=8, LSB_FIRST=0, in_enable=1, write 8'hAA once -> out_bit 1,0,1,0,1,0,1,0 on the 8 cycles after the write. out_first on cycle 1, out_last on cycle 8. Then out_valid=0 and out_bit=0.
- Write 8'hAA, then 8'h35 two cycles later -> 16 contiguous valid bits. The second word reads 0,0,1,1,0,1,0,1. out_ready is 0 from the second write until its transfer.
- LSB_FIRST=1, write 8'h35 -> 1,0,1,0,1,1,0,0.
- Write 8'hAA, then toggle in_enable 1,0,0,1,... -> each bit is held across the disabled cycles. out_last appears only after 8 enabled edges.
- Three writes on consecutive cycles while a word is shifting -> the third is dropped and out_overrun=1. The first two words are sent intact. out_overrun stays 1 until reset.
- Assert in_reset at bit 3 of 8'hAA with buf_full=1 -> all outputs immediately take their reset values. After release, no further valid bits appear until a new write.
